score_event_arbiter: RTL and testbench
======================================

# score_event_arbiter

Collects note-hit events from the per-lane hit detectors and sequences them into the scoreboard's single `increment`/`islong` interface, which accepts at most one scoring event per clock. Each lane has a small FIFO so that simultaneous hits on several lanes are serialised rather than lost. A round-robin arbiter drains the FIFOs. The block also keeps the combo (streak) count shown by the display logic, and sits between the lane hit detectors and `scoreboard`.

## Interface
Parameters:
- `NLANES`, 4: number of note lanes (2..8).
- `DEPTH`, 4: per-lane FIFO depth in events (power of two, ≥2).
- `COMBO_W`, 8: combo counter width.

Ports:
- `clk` in 1: system clock; all state changes on its rising edge.
- `resetn` in 1: reset, asynchronous assert, active-low. All state clears immediately when low.
- `hit_req` in NLANES: one-cycle pulse per lane when a note is hit.
- `hit_long` in NLANES: qualifies `hit_req` on the same bit/cycle; 1 means a long note.
- `miss` in NLANES: one-cycle pulse per lane when a note is missed.
- `hold` in 1: pause; while high, no events are issued (queuing continues).
- `increment` out 1: one-cycle scoring pulse to `scoreboard`.
- `islong` out 1: long-note flag, valid with `increment`, 0 otherwise.
- `grant_lane` out $clog2(NLANES): lane of the current `increment`, 0 otherwise.
- `combo` out COMBO_W: current streak.
- `overflow` out 1: sticky; a hit was dropped on a full FIFO.
- `busy` out 1: high when any FIFO is non-empty.

## Operation
- **Push.** Each cycle, for every lane with `hit_req[i]=1`, the value `hit_long[i]` is written into lane i's FIFO. All lanes can push in the same cycle.
- **Full FIFO.**
  - If lane i is full and is also being popped in the same cycle, the push is accepted.
  - Otherwise the push is dropped and `overflow` is set to 1. Only reset clears `overflow`.
- **Arbitration.**
  - When `hold=0` and at least one FIFO is non-empty, exactly one lane is popped per cycle.
  - The grant goes to the first non-empty lane, searching upward (modulo NLANES) from `rr_ptr`.
  - After a grant, `rr_ptr` becomes the granted lane + 1, wrapping NLANES-1 → 0.
  - On reset, `rr_ptr` = 0.
- **Issue.** The popped head bit is registered. On the next cycle the block drives `increment=1`, `islong`=head bit and `grant_lane`=the lane.
- **Combo.**
  - `combo` increments by 1 for each issued `increment` and saturates at all-ones.
  - Any `miss` bit set clears `combo` to 0.
  - Miss and issue in the same cycle: the clear wins, so `combo`=0.
  - `miss` does not touch any FIFO contents.
- **Hold.**
  - `hold` is sampled at arbitration. If `hold=1` in cycle N, there is no pop in N and `increment=0` in N+1.
  - An `increment` already registered (from a pop in N-1) still appears in N.
- **`busy`.** Combinational OR of the FIFO non-empty flags.
- **Reset mid-operation.** All FIFOs are emptied, pending events are discarded, and all outputs go to 0 asynchronously.

## Timing
- Reset values: `increment`=0, `islong`=0, `grant_lane`=0, `combo`=0, `overflow`=0, `busy`=0.
- Latency: a `hit_req` at edge N on an idle block, with no contention and `hold=0`, produces `increment` high during cycle N+2. Cycle N+1 is the FIFO write/arbitration cycle.
- Throughput: one event per cycle, sustained, while any FIFO is non-empty.
- Fairness: a waiting event waits at most NLANES-1 grants to other lanes before its lane is served.
- `increment` is never high on two consecutive cycles for the same single queued event. It is high on consecutive cycles only when several events are queued.
- Outputs `increment`, `islong`, `grant_lane`, `combo` and `overflow` are registered. `busy` is combinational.

## Structure
- Shared package `rhythm_pkg`:
  - `NLANES_DEF`, `FIFO_DEPTH_DEF`, `COMBO_W_DEF`.
  - A `lane_idx_t` typedef.
  - An `EVT_SHORT=0` / `EVT_LONG=1` encoding.
- Sub-module `lane_fifo`:
  - 1-bit wide, DEPTH deep, with `push`, `pop`, `din`, `dout`, `empty`, `full`.
  - Same-cycle push+pop is legal when full.
  - Instantiated NLANES times.
- The arbiter, round-robin pointer, issue register and combo counter live in the top module.

## Test plan
- Reset, then a single `hit_req[2]=1`, `hit_long[2]=0` → `increment`=1 and `islong`=0 exactly two cycles later, `grant_lane`=2, `combo`=1.
- All four lanes hit in one cycle, with `hit_long`=4'b0101 → four consecutive `increment` pulses with `grant_lane` 0,1,2,3 and `islong` 1,0,1,0; `combo`=4; `busy` falls after the last pop.
- Lane 1: five hits in consecutive cycles with `hold=1` (DEPTH=4) → `overflow`=1. Release `hold` → exactly four `increment` pulses, all with `grant_lane`=1.
- Combo saturation: 260 short hits on lane 0 → `combo` stays at 255. Then `miss[3]` in the same cycle as an issue → `combo`=0.
- Round-robin fairness: lane 0 hit every cycle and lane 3 hit once → lane 3 is granted within 4 grants.
- Assert `resetn`=0 asynchronously mid-burst with three events queued → all outputs are 0 immediately. After release, no stale `increment` is issued.

Source files
------------

// File: rtl/rhythm_pkg.sv
// Shared types and defaults for the rhythm-game scoring path.
// Lane indices are sized for the largest supported lane count.
package rhythm_pkg;

   localparam int NLANES_DEF     = 4;
   localparam int FIFO_DEPTH_DEF = 4;
   localparam int COMBO_W_DEF    = 8;
   localparam int LANE_MAX       = 8;

   typedef logic [2:0] lane_idx_t;

   typedef enum logic {
      EVT_SHORT = 1'b0,
      EVT_LONG  = 1'b1
   } evt_t;

   // First requesting lane at or above start, wrapping at nlanes; start if none.
   function automatic lane_idx_t rr_pick(input logic [LANE_MAX-1:0] req,
                                         input lane_idx_t           start,
                                         input int                  nlanes);
      lane_idx_t cand;
      lane_idx_t pick;
      logic      found;
      cand  = start;
      pick  = start;
      found = 1'b0;
      for (int k = 0; k < LANE_MAX; k++) begin
         if (k < nlanes) begin
            if (!found && req[cand]) begin
               pick  = cand;
               found = 1'b1;
            end
            cand = (int'(cand) == nlanes - 1) ? '0 : cand + 3'd1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/lane_fifo.sv
// One-bit-wide event FIFO for a single lane; a push into a full FIFO is
// accepted when the same cycle also pops it.
module lane_fifo #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic resetn,
   input  logic push,
   input  logic pop,
   input  logic din,
   output logic dout,
   output logic empty,
   output logic full
);

   localparam int AW = $clog2(DEPTH);

   // Extra MSB on each pointer separates full from empty when addresses match.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [DEPTH-1:0] mem;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   // NOTE: storage is deliberately not reset; the pointers alone decide which
   // entries are valid, so clearing them empties the FIFO.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

   // NOTE: sequential state is written with <= so every flop samples the
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/score_event_arbiter.sv
// Serialises per-lane note hits into the scoreboard's one-event-per-cycle
// increment/islong interface and tracks the combo streak.
module score_event_arbiter
   import rhythm_pkg::*;
#(
   parameter int NLANES  = NLANES_DEF,
   parameter int DEPTH   = FIFO_DEPTH_DEF,
   parameter int COMBO_W = COMBO_W_DEF
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [NLANES-1:0]         hit_req,
   input  logic [NLANES-1:0]         hit_long,
   input  logic [NLANES-1:0]         miss,
   input  logic                      hold,
   output logic                      increment,
   output logic                      islong,
   output logic [$clog2(NLANES)-1:0] grant_lane,
   output logic [COMBO_W-1:0]        combo,
   output logic                      overflow,
   output logic                      busy
);

   localparam int LW = $clog2(NLANES);

   logic [NLANES-1:0]   empty;
   logic [NLANES-1:0]   full;
   logic [NLANES-1:0]   head;
   logic [NLANES-1:0]   pop;
   logic [NLANES-1:0]   drop;
   logic [LANE_MAX-1:0] req_vec;
   logic [LANE_MAX-1:0] head_vec;
   lane_idx_t           rr_ptr;
   lane_idx_t           grant_idx;
   lane_idx_t           rr_next;
   logic                grant_vld;

   assign busy = |(~empty);

   // NOTE: every always_comb output gets a default before any partial or
   // conditional assignment, so no latch can be inferred.
   always_comb begin
      req_vec                = '0;
      head_vec               = '0;
      req_vec[NLANES-1:0]    = ~empty;
      head_vec[NLANES-1:0]   = head;
      grant_vld              = !hold && busy;
      grant_idx              = rr_pick(req_vec, rr_ptr, NLANES);
      rr_next                = (int'(grant_idx) == NLANES - 1) ? '0 : grant_idx + 3'd1;
   end

   for (genvar i = 0; i < NLANES; i++) begin : g_lane
      assign pop[i]  = grant_vld && (grant_idx == lane_idx_t'(i));
      // A full lane still takes the push when the arbiter drains it this cycle.
      assign drop[i] = hit_req[i] && full[i] && !pop[i];

      lane_fifo #(
         .DEPTH(DEPTH)
      ) u_fifo (
         .clk   (clk),
         .resetn(resetn),
         .push  (hit_req[i]),
         .pop   (pop[i]),
         .din   (hit_long[i]),
         .dout  (head[i]),
         .empty (empty[i]),
         .full  (full[i])
      );
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rr_ptr     <= '0;
         increment  <= 1'b0;
         islong     <= 1'b0;
         grant_lane <= '0;
         combo      <= '0;
         overflow   <= 1'b0;
      end else begin
         increment  <= grant_vld;
         islong     <= grant_vld && (evt_t'(head_vec[grant_idx]) == EVT_LONG);
         grant_lane <= grant_vld ? grant_idx[LW-1:0] : '0;
         if (grant_vld) rr_ptr <= rr_next;

         // A miss in the same cycle as a pop leaves the streak at zero.
         if (|miss)
            combo <= '0;
         else if (grant_vld && (combo != '1))
            combo <= combo + COMBO_W'(1);

         if (|drop) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_score_event_arbiter.sv
// Scoreboard bench for score_event_arbiter: a queue-based lane model predicts
// each issued event; a monitor compares whenever the DUT presents increment.
module tb_score_event_arbiter;

   localparam int NL = 4;
   localparam int DP = 4;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic [NL-1:0] hit_req = '0;
   logic [NL-1:0] hit_long = '0;
   logic [NL-1:0] miss = '0;
   logic          hold = 1'b0;
   logic          increment;
   logic          islong;
   logic [1:0]    grant_lane;
   logic [CW-1:0] combo;
   logic          overflow;
   logic          busy;

   score_event_arbiter #(
      .NLANES (NL),
      .DEPTH  (DP),
      .COMBO_W(CW)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .hit_req   (hit_req),
      .hit_long  (hit_long),
      .miss      (miss),
      .hold      (hold),
      .increment (increment),
      .islong    (islong),
      .grant_lane(grant_lane),
      .combo     (combo),
      .overflow  (overflow),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: one queue per lane, a round-robin start lane, and the
   // list of events the DUT owes, each stamped with the cycle it must appear.
   typedef struct {
      int   lane;
      logic lng;
      int   due;
   } exp_t;

   exp_t sb[$];
   bit   lane_q[NL][$];
   int   m_rr     = 0;
   bit   m_ovf    = 1'b0;
   int   m_combo  = 0;
   int   m_popped;
   bit   m_bit;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NL; i++) lane_q[i].delete();
         sb.delete();
         m_rr    = 0;
         m_ovf   = 1'b0;
         m_combo = 0;
      end else begin
         cyc++;
         m_popped = -1;
         if (!hold)
            for (int k = 0; k < NL; k++)
               if (m_popped < 0 && lane_q[(m_rr + k) % NL].size() > 0) m_popped = (m_rr + k) % NL;
         if (m_popped >= 0) begin
            m_bit = lane_q[m_popped].pop_front();
            sb.push_back('{m_popped, m_bit, cyc});
            m_rr = (m_popped + 1) % NL;
         end
         for (int i = 0; i < NL; i++)
            if (hit_req[i]) begin
               if (lane_q[i].size() < DP) lane_q[i].push_back(hit_long[i]);
               else m_ovf = 1'b1;
            end
         if (|miss) m_combo = 0;
         else if (m_popped >= 0 && m_combo < (1 << CW) - 1) m_combo++;
      end
   end

   // Monitor: outputs are sampled on the falling edge, away from the active edge.
   exp_t mon_e;
   bit   m_any;
   always @(negedge clk) begin
      if (resetn) begin
         if (increment) begin
            if (sb.size() == 0) check("unexpected_increment", increment, 0);
            else begin
               mon_e = sb.pop_front();
               check("grant_lane", grant_lane, mon_e.lane);
               check("islong", islong, mon_e.lng);
               check("issue_cycle", cyc, mon_e.due);
            end
         end else begin
            if (sb.size() > 0 && sb[0].due <= cyc) begin
               check("missing_increment", increment, 1);
               void'(sb.pop_front());
            end
            check("idle_islong", islong, 0);
            check("idle_grant_lane", grant_lane, 0);
         end
         m_any = 1'b0;
         for (int i = 0; i < NL; i++) if (lane_q[i].size() > 0) m_any = 1'b1;
         check("combo", combo, m_combo);
         check("overflow", overflow, m_ovf);
         check("busy", busy, m_any);
      end
   end

   // Fairness watch: grants seen between the lane-3 hit and lane 3's own grant.
   bit fair_arm  = 1'b0;
   bit fair_seen = 1'b0;
   int fair_cnt  = 0;
   always @(negedge clk) begin
      if (fair_arm && increment) begin
         fair_cnt++;
         if (grant_lane == 2'd3) begin
            fair_seen = 1'b1;
            fair_arm  = 1'b0;
         end
      end
   end

   task automatic tick(input logic [NL-1:0] hr, input logic [NL-1:0] hl,
                       input logic [NL-1:0] ms, input logic hd);
      @(negedge clk);
      hit_req  = hr;
      hit_long = hl;
      miss     = ms;
      hold     = hd;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick('0, '0, '0, 1'b0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
   endtask

   initial begin
      #3;
      check("rst_increment", increment, 0);
      check("rst_islong", islong, 0);
      check("rst_grant_lane", grant_lane, 0);
      check("rst_combo", combo, 0);
      check("rst_overflow", overflow, 0);
      check("rst_busy", busy, 0);
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;

      // Single short hit on lane 2.
      tick(4'b0100, 4'b0000, '0, 1'b0);
      idle(5);
      #1 check("single_hit_combo", combo, 1);

      // All lanes at once from a fresh round-robin pointer.
      pulse_reset();
      tick(4'b1111, 4'b0101, '0, 1'b0);
      idle(8);
      #1 check("burst_combo", combo, 4);
      check("burst_busy", busy, 0);

      // Five holds-worth of lane-1 hits into a depth-4 FIFO.
      for (int i = 0; i < 5; i++) tick(4'b0010, 4'b0000, '0, 1'b1);
      tick('0, '0, '0, 1'b1);
      #1 check("hold_overflow", overflow, 1);
      check("hold_busy", busy, 1);
      idle(8);
      #1 check("hold_combo", combo, 8);

      // Combo saturation, then a miss while lane 0 keeps issuing.
      for (int i = 0; i < 260; i++) tick(4'b0001, 4'b0000, '0, 1'b0);
      idle(4);
      #1 check("combo_saturated", combo, 255);
      for (int i = 0; i < 3; i++) tick(4'b0001, 4'b0000, '0, 1'b0);
      tick(4'b0001, 4'b0000, 4'b1000, 1'b0);
      tick(4'b0001, 4'b0000, '0, 1'b0);
      #1 check("miss_clears_combo", combo, 0);
      idle(4);

      // Fairness: lane 0 hammered, lane 3 hit once.
      for (int i = 0; i < 12; i++) begin
         if (i == 3) begin
            tick(4'b1001, 4'b1000, '0, 1'b0);
            fair_arm = 1'b1;
         end else tick(4'b0001, 4'b0000, '0, 1'b0);
      end
      idle(16);
      check("fair_lane3_served", fair_seen, 1);
      check("fair_grants_le_4", fair_cnt <= 4, 1);

      // Asynchronous reset in the middle of a burst.
      tick(4'b1111, 4'b1010, '0, 1'b0);
      tick('0, '0, '0, 1'b0);
      @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      check("arst_increment", increment, 0);
      check("arst_islong", islong, 0);
      check("arst_grant_lane", grant_lane, 0);
      check("arst_combo", combo, 0);
      check("arst_overflow", overflow, 0);
      check("arst_busy", busy, 0);
      @(negedge clk);
      resetn = 1'b1;
      idle(8);
      #1 check("post_reset_busy", busy, 0);

      // Randomised traffic with holds and occasional misses.
      for (int n = 0; n < 400; n++)
         tick(4'($urandom_range(0, 15) & $urandom_range(0, 15)),
              4'($urandom_range(0, 15)),
              ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000,
              $urandom_range(0, 3) == 0);
      idle(30);
      #1 check("final_drain_busy", busy, 0);
      check("final_scoreboard_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
